// File: rtl/qupdate_scheduler.sv
// qupdate_scheduler
// -----------------
// Issue controller for the Q-learning update pipeline. It accepts
// transitions (s, a, r, s') over a valid/ready handshake and issues each one
// to the pipeline with a one-cycle clock enable. It tracks in-flight updates
// so that read-after-write hazards on the Q-table are stalled, raises the
// write-back strobe when a result leaves the pipeline, and owns the
// alpha/gamma configuration registers that feed the datapath.
//
// Handshake: a transition transfers in the cycle where in_valid && in_ready
// are both high at the rising edge. in_ready depends combinationally on
// in_s/in_s_next (hazard check), so the requester must hold its data stable
// while in_valid is high. in_ready never depends on in_valid.
//
// Ports:
//   clk, rst                 clock (rising edge), synchronous active-high reset
//   in_valid/in_ready        transition handshake
//   in_s/in_a/in_r/in_s_next transition fields
//   cfg_we/cfg_alpha/cfg_gamma  configuration write (applied after draining)
//   pipe_ce, pipe_*          one-cycle issue enable and registered operands
//   alpha, gamma             active learning-rate / discount to the datapath
//   pipe_sum                 pipeline result
//   wb_we/wb_s/wb_a/wb_data  Q-table write-back
//   busy                     op in flight, or draining / applying config
//   done_cnt                 completed updates, wraps modulo 2^16
//   stall_cnt                stalled-request cycles (only with QSCHED_STATS_EN)
//   dbg_state                current FSM state (0 IDLE, 1 RUN, 2 DRAIN, 3 CFG)
//
// Build option: define QSCHED_STATS_EN to include the saturating stall
// counter; without it stall_cnt is tied to zero.

module qupdate_scheduler #(
  parameter int         SW         = 6,
  parameter int         AW         = 2,
  parameter int         RW         = 8,
  parameter int         DW         = 24,
  parameter int         LAT        = 4,
  parameter logic [7:0] ALPHA_INIT = 8'h01,
  parameter logic [7:0] GAMMA_INIT = 8'h01
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [SW-1:0] in_s,
  input  logic [AW-1:0] in_a,
  input  logic [RW-1:0] in_r,
  input  logic [SW-1:0] in_s_next,
  input  logic          cfg_we,
  input  logic [7:0]    cfg_alpha,
  input  logic [7:0]    cfg_gamma,
  output logic          pipe_ce,
  output logic [SW-1:0] pipe_s,
  output logic [AW-1:0] pipe_a,
  output logic [RW-1:0] pipe_r,
  output logic [SW-1:0] pipe_s_next,
  output logic [7:0]    alpha,
  output logic [7:0]    gamma,
  input  logic [DW-1:0] pipe_sum,
  output logic          wb_we,
  output logic [SW-1:0] wb_s,
  output logic [AW-1:0] wb_a,
  output logic [DW-1:0] wb_data,
  output logic          busy,
  output logic [15:0]   done_cnt,
  output logic [15:0]   stall_cnt,
  output logic [1:0]    dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_CFG   = 2'd3
  } state_e;

  state_e state_q, state_d;

  // Tracker: stage 0 is loaded on the edge that issues an op, so it is valid
  // in the pipe_ce cycle; stage LAT is valid exactly LAT cycles later, which
  // is when pipe_sum carries that op's result.
  logic [LAT:0]  trk_v_q;
  logic [SW-1:0] trk_s_q [LAT+1];
  logic [AW-1:0] trk_a_q [LAT+1];

  logic          pipe_ce_q;
  logic [SW-1:0] pipe_s_q, pipe_s_next_q;
  logic [AW-1:0] pipe_a_q;
  logic [RW-1:0] pipe_r_q;
  logic [7:0]    alpha_q, gamma_q, pend_alpha_q, pend_gamma_q;
  logic [15:0]   done_cnt_q;

  logic hazard, hs, trk_any, accepting;

  // Hazard against every valid tracker entry, including stage 0 (the op
  // being issued this cycle) and the tail (the op writing back this cycle).
  // The tail's hazard therefore clears only in the cycle after its wb_we.
  always_comb begin
    hazard = 1'b0;
    for (int i = 0; i <= LAT; i++) begin
      if (trk_v_q[i] && (trk_s_q[i] == in_s || trk_s_q[i] == in_s_next)) begin
        hazard = 1'b1;
      end
    end
  end

  assign trk_any   = |trk_v_q;
  assign accepting = (state_q == ST_IDLE) || (state_q == ST_RUN);
  assign hs        = in_valid && in_ready;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic. A transition accepted together with cfg_we still has
  // to drain, so the direct jump to CFG also requires no handshake.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_RUN: begin
        if (cfg_we) begin
          state_d = (!trk_any && !hs) ? ST_CFG : ST_DRAIN;
        end else if (hs) begin
          state_d = ST_RUN;
        end else if (!trk_any) begin
          state_d = ST_IDLE;
        end
      end
      ST_DRAIN: if (!trk_any) state_d = ST_CFG;
      ST_CFG:   state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Output logic. RUN with an empty tracker is idle-equivalent, so busy only
  // counts DRAIN/CFG besides in-flight ops; it falls the cycle after the
  // final write-back.
  always_comb begin
    in_ready  = accepting && !hazard && !rst;
    wb_we     = trk_v_q[LAT] && !rst;
    wb_s      = trk_s_q[LAT];
    wb_a      = trk_a_q[LAT];
    wb_data   = pipe_sum;
    busy      = trk_any || (state_q == ST_DRAIN) || (state_q == ST_CFG);
    dbg_state = state_q;
  end

  // Issue registers: operands hold their last value when nothing issues.
  always_ff @(posedge clk) begin
    if (rst) begin
      pipe_ce_q     <= 1'b0;
      pipe_s_q      <= '0;
      pipe_a_q      <= '0;
      pipe_r_q      <= '0;
      pipe_s_next_q <= '0;
    end else begin
      pipe_ce_q <= hs;
      if (hs) begin
        pipe_s_q      <= in_s;
        pipe_a_q      <= in_a;
        pipe_r_q      <= in_r;
        pipe_s_next_q <= in_s_next;
      end
    end
  end

  // Tracker shift register
  always_ff @(posedge clk) begin
    if (rst) begin
      trk_v_q <= '0;
      for (int i = 0; i <= LAT; i++) begin
        trk_s_q[i] <= '0;
        trk_a_q[i] <= '0;
      end
    end else begin
      trk_v_q    <= {trk_v_q[LAT-1:0], hs};
      trk_s_q[0] <= hs ? in_s : '0;
      trk_a_q[0] <= hs ? in_a : '0;
      for (int i = 1; i <= LAT; i++) begin
        trk_s_q[i] <= trk_s_q[i-1];
        trk_a_q[i] <= trk_a_q[i-1];
      end
    end
  end

  // Configuration: requests land in pending registers and only reach the
  // datapath in the CFG cycle, after every in-flight op has written back.
  // A request arriving in the CFG cycle itself is applied directly.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_alpha_q <= ALPHA_INIT;
      pend_gamma_q <= GAMMA_INIT;
      alpha_q      <= ALPHA_INIT;
      gamma_q      <= GAMMA_INIT;
    end else begin
      if (cfg_we) begin
        pend_alpha_q <= cfg_alpha;
        pend_gamma_q <= cfg_gamma;
      end
      if (state_q == ST_CFG) begin
        alpha_q <= cfg_we ? cfg_alpha : pend_alpha_q;
        gamma_q <= cfg_we ? cfg_gamma : pend_gamma_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst)        done_cnt_q <= '0;
    else if (wb_we) done_cnt_q <= done_cnt_q + 16'd1;
  end

`ifdef QSCHED_STATS_EN
  logic [15:0] stall_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
    end else if (in_valid && !in_ready && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_q <= stall_cnt_q + 16'd1;
    end
  end

  assign stall_cnt = stall_cnt_q;
`else
  assign stall_cnt = 16'h0000;
`endif

  assign pipe_ce     = pipe_ce_q;
  assign pipe_s      = pipe_s_q;
  assign pipe_a      = pipe_a_q;
  assign pipe_r      = pipe_r_q;
  assign pipe_s_next = pipe_s_next_q;
  assign alpha       = alpha_q;
  assign gamma       = gamma_q;
  assign done_cnt    = done_cnt_q;

endmodule
